dm_cache_data_array: RTL and testbench
======================================

Name: dm_cache_data_array

Overview:
- Parametrised cache data array. Successor to the single-port, 1024-entry, combinational-read data memory.
- Adds multi-way storage, multi-word lines, byte-enable CPU writes, a registered read port, and a line engine.
- The line engine streams a whole line in (refill from next level) or out (eviction/writeback) over valid/ready.
- Sits between the cache controller (tag/valid logic, issues requests and line commands) and the memory-side bus adapter.

Parameters:
- SETS, 1024, number of sets (power of 2).
- WAYS, 2, associativity (power of 2, 1 = direct-mapped).
- WORDS, 4, words per line (power of 2, >=2).
- DATA_W, 32, word width in bits (multiple of 8).
- Derived: SET_W=$clog2(SETS), WAY_W=max(1,$clog2(WAYS)), OFF_W=$clog2(WORDS), BE_W=DATA_W/8.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active high.
- cpu_req  in  1  CPU word access request; held until granted.
- cpu_we  in  1  1=write, 0=read.
- cpu_way  in  WAY_W  way select.
- cpu_set  in  SET_W  set index.
- cpu_word  in  OFF_W  word offset in line.
- cpu_be  in  BE_W  byte enables (writes only).
- cpu_wdata  in  DATA_W  write data.
- cpu_gnt  out  1  request accepted this cycle (combinational).
- cpu_rvalid  out  1  read data valid pulse.
- cpu_rdata  out  DATA_W  registered read data.
- fill_start  in  1  begin line refill.
- evict_start  in  1  begin line readout.
- line_way  in  WAY_W  way for line command (sampled on start).
- line_set  in  SET_W  set for line command (sampled on start).
- fill_valid  in  1  refill beat valid.
- fill_data  in  DATA_W  refill beat data.
- fill_ready  out  1  array accepts refill beat.
- evict_valid  out  1  eviction beat valid.
- evict_data  out  DATA_W  eviction beat data.
- evict_ready  in  1  downstream accepts eviction beat.
- busy  out  1  line engine not IDLE.
- line_done  out  1  one-cycle pulse, line command completed.

Behaviour:
- Storage: SETS*WAYS*WORDS words of DATA_W. Contents are not reset (X after power-up).
- Reset (async, rst=1): state IDLE, beat counter 0. All outputs 0: cpu_rvalid, cpu_rdata, evict_valid, evict_data, fill_ready, busy, line_done.
- States:
  - IDLE -> EVICT on evict_start.
  - IDLE -> FILL on fill_start.
  - evict_start and fill_start together: EVICT taken, fill_start ignored.
  - Starts are ignored outside IDLE.
  - line_way/line_set are latched on start.
- cpu_gnt = cpu_req & IDLE & !fill_start & !evict_start. Line commands win over the CPU; an ungranted request must be held.
- Granted read: cpu_rdata <= mem[set][way][word] at the grant edge; cpu_rvalid=1 for exactly the next cycle. cpu_rdata holds until the next granted read.
- Granted write: each byte i with cpu_be[i]=1 is updated at the grant edge; other bytes are unchanged. be=0 leaves the word unchanged but is still granted.
- Write then read of the same word on the next cycle returns the new data (no stale read).
- FILL:
  - fill_ready=1 throughout.
  - Each fill_valid & fill_ready writes fill_data (full word) at offset = beat, then beat++.
  - The beat with offset WORDS-1 returns the engine to IDLE; line_done=1 the following cycle; beat resets to 0.
- EVICT:
  - One-cycle read latency: evict_valid rises the cycle after entering EVICT, with evict_data = word 0.
  - On evict_valid & evict_ready: beat++ and the next word is presented the following cycle.
  - Insertion of one-cycle bubbles between beats is permitted.
  - evict_data is stable while evict_valid & !evict_ready.
  - Handshake of word WORDS-1: evict_valid drops, engine returns to IDLE, line_done pulses the following cycle.
- busy=1 in FILL and EVICT, registered. CPU grants resume the cycle after return to IDLE.
- Beat counter is OFF_W bits and wraps to 0 at line end.
- Reset mid-burst: engine aborts to IDLE with no line_done. Words already filled keep their new values; the remainder keep old values.

Test Plan:
- Reset, then read set 5 way 1 word 2 after writing 0xDEADBEEF with be=4'hF -> cpu_rvalid one cycle after grant, cpu_rdata=0xDEADBEEF.
- Write 0x11223344 full, then 0xAABBCCDD with be=4'b0101 -> readback 0x11BB33DD.
- fill_start set 7 way 0; beats 0xA0..0xA3 with fill_valid toggling every other cycle -> 4 writes, line_done one pulse. CPU reads of words 0..3 return 0xA0..0xA3.
- evict_start on the same line with evict_ready low 3 cycles at beat 1 -> evict_data stays 0xA1 while stalled. Sequence is 0xA0,0xA1,0xA2,0xA3, then line_done.
- cpu_req held with fill_start and evict_start asserted in the same cycle -> evict runs, fill ignored. cpu_gnt=0 until the cycle after busy falls, then granted.
- rst pulsed after fill beat 1 -> busy=0, no line_done. Words 0..1 hold new data, words 2..3 hold old data.

Source files
------------

// File: rtl/dm_cache_data_array.sv
// Cache data array: SETS x WAYS lines of WORDS words each.
// CPU port: byte-enable writes and registered reads. Line engine: streams a
// whole line in (refill) or out (eviction) over valid/ready.
// Line commands take priority over CPU accesses.
module dm_cache_data_array #(
    parameter int SETS   = 1024,
    parameter int WAYS   = 2,
    parameter int WORDS  = 4,
    parameter int DATA_W = 32,
    localparam int SET_W = $clog2(SETS),
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int OFF_W = $clog2(WORDS),
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [WAY_W-1:0]  cpu_way,
    input  logic [SET_W-1:0]  cpu_set,
    input  logic [OFF_W-1:0]  cpu_word,
    input  logic [BE_W-1:0]   cpu_be,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              fill_start,
    input  logic              evict_start,
    input  logic [WAY_W-1:0]  line_way,
    input  logic [SET_W-1:0]  line_set,
    input  logic              fill_valid,
    input  logic [DATA_W-1:0] fill_data,
    output logic              fill_ready,
    output logic              evict_valid,
    output logic [DATA_W-1:0] evict_data,
    input  logic              evict_ready,
    output logic              busy,
    output logic              line_done
);

    localparam int DEPTH  = SETS * WAYS * WORDS;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, EVICT} state_t;

    state_t            state;
    logic [OFF_W-1:0]  beat;
    logic [OFF_W-1:0]  beat_inc;
    logic [WAY_W-1:0]  lway;
    logic [SET_W-1:0]  lset;
    logic              last_beat;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;

    // Flat word address; way is reduced modulo WAYS so a 1-way array ignores it.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [SET_W-1:0] s,
                                                    input logic [WAY_W-1:0] w,
                                                    input logic [OFF_W-1:0] o);
        return (ADDR_W'(s) * ADDR_W'(WAYS) + (ADDR_W'(w) % ADDR_W'(WAYS)))
               * ADDR_W'(WORDS) + ADDR_W'(o);
    endfunction

    assign cpu_gnt   = cpu_req & (state == IDLE) & ~fill_start & ~evict_start;
    assign beat_inc  = beat + OFF_W'(1);
    assign last_beat = (beat == OFF_W'(WORDS - 1));

    // Single write port: refill beats (full word) or granted CPU writes (byte enables).
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = word_addr(cpu_set, cpu_way, cpu_word);
        wr_data = cpu_wdata;
        wr_be   = cpu_be;
        if (state == FILL && fill_valid) begin
            wr_en   = 1'b1;
            wr_addr = word_addr(lset, lway, beat);
            wr_data = fill_data;
            wr_be   = '1;
        end else if (cpu_gnt && cpu_we) begin
            wr_en   = 1'b1;
        end
    end

    // Storage array, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Line engine FSM plus registered CPU read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            beat        <= '0;
            lway        <= '0;
            lset        <= '0;
            busy        <= 1'b0;
            fill_ready  <= 1'b0;
            evict_valid <= 1'b0;
            evict_data  <= '0;
            line_done   <= 1'b0;
            cpu_rvalid  <= 1'b0;
            cpu_rdata   <= '0;
        end else begin
            line_done  <= 1'b0;
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            if (cpu_gnt && !cpu_we) cpu_rdata <= mem[word_addr(cpu_set, cpu_way, cpu_word)];

            case (state)
                IDLE: begin
                    if (evict_start) begin
                        state <= EVICT;
                        busy  <= 1'b1;
                        lway  <= line_way;
                        lset  <= line_set;
                        beat  <= '0;
                    end else if (fill_start) begin
                        state      <= FILL;
                        busy       <= 1'b1;
                        fill_ready <= 1'b1;
                        lway       <= line_way;
                        lset       <= line_set;
                        beat       <= '0;
                    end
                end
                FILL: begin
                    if (fill_valid) begin
                        if (last_beat) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            fill_ready <= 1'b0;
                            line_done  <= 1'b1;
                            beat       <= '0;
                        end else begin
                            beat <= beat_inc;
                        end
                    end
                end
                EVICT: begin
                    // First cycle fetches word 0; afterwards each accepted beat
                    // prefetches the next word so beats can stream back to back.
                    if (!evict_valid) begin
                        evict_valid <= 1'b1;
                        evict_data  <= mem[word_addr(lset, lway, beat)];
                    end else if (evict_ready) begin
                        if (last_beat) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            evict_valid <= 1'b0;
                            line_done   <= 1'b1;
                            beat        <= '0;
                        end else begin
                            beat       <= beat_inc;
                            evict_data <= mem[word_addr(lset, lway, beat_inc)];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_data_array.sv
// Directed bench for dm_cache_data_array with default parameters.
module tb_dm_cache_data_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [0:0]  cpu_way;
    logic [9:0]  cpu_set;
    logic [1:0]  cpu_word;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        fill_start, evict_start;
    logic [0:0]  line_way;
    logic [9:0]  line_set;
    logic        fill_valid;
    logic [31:0] fill_data;
    logic        fill_ready, evict_valid;
    logic [31:0] evict_data;
    logic        evict_ready, busy, line_done;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;

    dm_cache_data_array dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_way(cpu_way), .cpu_set(cpu_set),
        .cpu_word(cpu_word), .cpu_be(cpu_be), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .fill_start(fill_start), .evict_start(evict_start),
        .line_way(line_way), .line_set(line_set),
        .fill_valid(fill_valid), .fill_data(fill_data), .fill_ready(fill_ready),
        .evict_valid(evict_valid), .evict_data(evict_data), .evict_ready(evict_ready),
        .busy(busy), .line_done(line_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (line_done) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string tag);
        int n = 0;
        while (!cpu_gnt && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_gnt"}, 32'(cpu_gnt), 32'd1);
    endtask

    task automatic cpu_write(input logic [9:0] s, input logic w, input logic [1:0] o,
                             input logic [3:0] be, input logic [31:0] d);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_set = s; cpu_way = w; cpu_word = o;
        cpu_be = be; cpu_wdata = d;
        wait_gnt("wr");
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [9:0] s, input logic w,
                            input logic [1:0] o, input logic [31:0] exp);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_set = s; cpu_way = w; cpu_word = o;
        wait_gnt(tag);
        tick();
        cpu_req = 1'b0;
        chk({tag, "_rvalid"}, 32'(cpu_rvalid), 32'd1);
        chk({tag, "_rdata"}, cpu_rdata, exp);
        tick();
        chk({tag, "_rvalid_drop"}, 32'(cpu_rvalid), 32'd0);
    endtask

    task automatic fill_beats(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            fill_valid = 1'b0;
            tick();
            fill_valid = 1'b1;
            fill_data  = base + 32'(i);
            tick();
        end
        fill_valid = 1'b0;
    endtask

    initial begin
        int idx, stall, n, beats;
        logic gnt_early, fr_seen;

        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_way = 0; cpu_set = 0; cpu_word = 0;
        cpu_be = 0; cpu_wdata = 0; fill_start = 0; evict_start = 0;
        line_way = 0; line_set = 0; fill_valid = 0; fill_data = 0; evict_ready = 0;
        tick();
        tick();
        chk("rst_rvalid", 32'(cpu_rvalid), 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_evict_valid", 32'(evict_valid), 0);
        chk("rst_evict_data", evict_data, 0);
        chk("rst_fill_ready", 32'(fill_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_line_done", 32'(line_done), 0);
        rst = 1'b0;
        tick();

        // Full write then immediate readback
        cpu_write(10'd5, 1'b1, 2'd2, 4'hF, 32'hDEADBEEF);
        cpu_read("rd_deadbeef", 10'd5, 1'b1, 2'd2, 32'hDEADBEEF);

        // Partial byte-enable write
        cpu_write(10'd5, 1'b1, 2'd3, 4'hF, 32'h11223344);
        cpu_write(10'd5, 1'b1, 2'd3, 4'b0101, 32'hAABBCCDD);
        cpu_read("rd_merge", 10'd5, 1'b1, 2'd3, 32'h11BB33DD);

        // be=0 write is granted but changes nothing
        cpu_write(10'd5, 1'b1, 2'd3, 4'b0000, 32'h0);
        cpu_read("rd_be0", 10'd5, 1'b1, 2'd3, 32'h11BB33DD);

        // Refill of set 7 way 0 with fill_valid toggling
        fill_start = 1'b1; line_set = 10'd7; line_way = 1'b0;
        tick();
        fill_start = 1'b0;
        chk("fill_busy", 32'(busy), 1);
        chk("fill_ready", 32'(fill_ready), 1);
        fill_beats(4, 32'hA0);
        chk("fill_done_pulse", 32'(line_done), 1);
        chk("fill_busy_end", 32'(busy), 0);
        chk("fill_ready_end", 32'(fill_ready), 0);
        tick();
        chk("fill_done_clear", 32'(line_done), 0);
        chk("fill_done_cnt", 32'(done_cnt), 1);
        for (int i = 0; i < 4; i++)
            cpu_read($sformatf("rd_fill_w%0d", i), 10'd7, 1'b0, 2'(i), 32'hA0 + 32'(i));

        // Eviction of the same line with a 3-cycle stall on beat 1
        evict_start = 1'b1; line_set = 10'd7; line_way = 1'b0;
        tick();
        evict_start = 1'b0;
        chk("evict_busy", 32'(busy), 1);
        chk("evict_latency", 32'(evict_valid), 0);
        idx = 0; stall = 0; n = 0;
        while (idx < 4 && n < 40) begin
            if (evict_valid) begin
                if (idx == 1 && stall < 3) begin
                    evict_ready = 1'b0;
                    chk("evict_stall_hold", evict_data, 32'hA1);
                    stall++;
                end else begin
                    evict_ready = 1'b1;
                    chk($sformatf("evict_w%0d", idx), evict_data, 32'hA0 + 32'(idx));
                    idx++;
                end
            end else begin
                evict_ready = 1'b0;
            end
            tick();
            n++;
        end
        evict_ready = 1'b0;
        chk("evict_beats", 32'(idx), 4);
        chk("evict_valid_drop", 32'(evict_valid), 0);
        chk("evict_done_pulse", 32'(line_done), 1);
        chk("evict_busy_end", 32'(busy), 0);
        tick();
        chk("evict_done_cnt", 32'(done_cnt), 2);

        // Simultaneous starts with a held CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_set = 10'd5; cpu_way = 1'b1; cpu_word = 2'd2;
        fill_start = 1'b1; evict_start = 1'b1; line_set = 10'd7; line_way = 1'b0;
        evict_ready = 1'b1;
        chk("both_start_gnt", 32'(cpu_gnt), 0);
        tick();
        fill_start = 1'b0; evict_start = 1'b0;
        gnt_early = 1'b0; fr_seen = 1'b0; beats = 0; n = 0;
        while (busy && n < 40) begin
            if (cpu_gnt) gnt_early = 1'b1;
            if (fill_ready) fr_seen = 1'b1;
            if (evict_valid && evict_ready) beats++;
            tick();
            n++;
        end
        evict_ready = 1'b0;
        chk("both_busy_end", 32'(busy), 0);
        chk("both_gnt_while_busy", 32'(gnt_early), 0);
        chk("both_fill_ignored", 32'(fr_seen), 0);
        chk("both_evict_beats", 32'(beats), 4);
        chk("both_done_pulse", 32'(line_done), 1);
        chk("both_gnt_resume", 32'(cpu_gnt), 1);
        tick();
        cpu_req = 1'b0;
        chk("both_rvalid", 32'(cpu_rvalid), 1);
        chk("both_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("both_done_cnt", 32'(done_cnt), 3);

        // Reset in the middle of a refill
        for (int i = 0; i < 4; i++)
            cpu_write(10'd9, 1'b1, 2'(i), 4'hF, 32'hB0 + 32'(i));
        fill_start = 1'b1; line_set = 10'd9; line_way = 1'b1;
        tick();
        fill_start = 1'b0;
        fill_beats(2, 32'hF0);
        chk("rstmid_busy_before", 32'(busy), 1);
        rst = 1'b1;
        #2;
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_fill_ready", 32'(fill_ready), 0);
        chk("rstmid_rdata", cpu_rdata, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("rstmid_no_done", 32'(line_done), 0);
        chk("rstmid_done_cnt", 32'(done_cnt), 3);
        cpu_read("rstmid_w0", 10'd9, 1'b1, 2'd0, 32'hF0);
        cpu_read("rstmid_w1", 10'd9, 1'b1, 2'd1, 32'hF1);
        cpu_read("rstmid_w2", 10'd9, 1'b1, 2'd2, 32'hB2);
        cpu_read("rstmid_w3", 10'd9, 1'b1, 2'd3, 32'hB3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
